// File: rtl/theremin_multichannel_period_measure.sv
// theremin_multichannel_period_measure
// N-channel oversampled period meter. Each channel receives one word of
// SAMPLE_BITS samples per clock (bit 0 earliest). It reports the edge-to-edge
// period in sample ticks, an IIR-smoothed fixed-point period, a one-cycle valid
// strobe and a signal-lost flag. Channels share only the clock and the reset.
//
// Pipeline per channel:
//   stage 1 : register the sample word and the edge mode
//   stage 2 : edge detect, tick counter, arm FSM -> PERIOD_RAW / PERIOD_VALID
//   stage 3 : IIR filter -> PERIOD_FILTERED
module theremin_multichannel_period_measure #(
  parameter int CHANNELS          = 2,
  parameter int SAMPLE_BITS       = 8,
  parameter int PERIOD_BITS       = 16,
  parameter int DATA_BITS         = 28,
  parameter int FILTER_SHIFT_BITS = 8
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [CHANNELS*SAMPLE_BITS-1:0] SAMPLES,
  input  logic [CHANNELS-1:0]             EDGE_MODE,
  output logic [CHANNELS*PERIOD_BITS-1:0] PERIOD_RAW,
  output logic [CHANNELS*DATA_BITS-1:0]   PERIOD_FILTERED,
  output logic [CHANNELS-1:0]             PERIOD_VALID,
  output logic [CHANNELS-1:0]             SIGNAL_LOST
);

  localparam int FRAC  = DATA_BITS - PERIOD_BITS;
  localparam int IDX_W = (SAMPLE_BITS > 4) ? 3 : 2;

  localparam logic [PERIOD_BITS-1:0] T_MAX     = {PERIOD_BITS{1'b1}};
  localparam logic [PERIOD_BITS:0]   T_MAX_EXT = {1'b0, {PERIOD_BITS{1'b1}}};
  localparam logic [PERIOD_BITS:0]   SB_EXT    = (PERIOD_BITS+1)'(SAMPLE_BITS);
  localparam logic [PERIOD_BITS-1:0] SB_TICKS  = PERIOD_BITS'(SAMPLE_BITS);

  // DISARMED: waiting for a reference edge. ARMED: reference edge seen, the
  // next edge yields the first measurement. TRACKING: measuring every edge.
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRACKING = 2'd2
  } arm_state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

    // stage 1
    logic [SAMPLE_BITS-1:0] word_r;
    logic                   mode_r;

    // stage 2
    logic                   prev_bit_r;
    logic                   mode_d_r;
    logic [PERIOD_BITS-1:0] tick_r;
    arm_state_t             state_r;
    logic [PERIOD_BITS-1:0] raw_r;
    logic                   valid_r;
    logic                   lost_r;
    logic                   direct_r;

    // stage 3
    logic [DATA_BITS-1:0]   filt_r;

    // combinational
    logic [SAMPLE_BITS-1:0] prev_s;
    logic [SAMPLE_BITS-1:0] qual_s;
    logic                   edge_s;
    logic [IDX_W-1:0]       pos_s;
    logic [PERIOD_BITS:0]   period_s;
    logic [PERIOD_BITS:0]   tick_sum_s;
    logic [PERIOD_BITS-1:0] tick_next_s;
    logic                   sat_s;
    logic                   mode_chg_s;
    logic [DATA_BITS-1:0]   x_s;
    logic signed [DATA_BITS:0] diff_s;
    logic signed [DATA_BITS:0] sum_s;
    logic [DATA_BITS-1:0]   filt_next_s;

    // Stage 1: capture this channel's sample word and edge mode.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        word_r <= '0;
        mode_r <= 1'b0;
      end else begin
        word_r <= SAMPLES[c*SAMPLE_BITS +: SAMPLE_BITS];
        mode_r <= EDGE_MODE[c];
      end
    end

    // Qualify transitions against the preceding sample and keep the latest one.
    always_comb begin
      prev_s = {word_r[SAMPLE_BITS-2:0], prev_bit_r};
      qual_s = '0;
      pos_s  = '0;
      for (int i = 0; i < SAMPLE_BITS; i++) begin
        if (mode_r) begin
          qual_s[i] = word_r[i] & ~prev_s[i];
        end else begin
          qual_s[i] = word_r[i] ^ prev_s[i];
        end
      end
      for (int i = 0; i < SAMPLE_BITS; i++) begin
        if (qual_s[i]) begin
          pos_s = IDX_W'(i);
        end else begin
          pos_s = pos_s;
        end
      end
      edge_s     = |qual_s;
      mode_chg_s = mode_r ^ mode_d_r;
    end

    // Period arithmetic, next tick count and the timeout condition. A counter
    // already parked at T_MAX does not time out again, so a restarted signal
    // can re-arm on its first edge.
    always_comb begin
      period_s   = {1'b0, tick_r} + (PERIOD_BITS+1)'(pos_s);
      tick_sum_s = {1'b0, tick_r} + SB_EXT;
      if (edge_s) begin
        sat_s       = (tick_r != T_MAX) && (period_s >= T_MAX_EXT);
        tick_next_s = SB_TICKS - PERIOD_BITS'(pos_s);
      end else begin
        sat_s = (tick_r != T_MAX) && (tick_sum_s >= T_MAX_EXT);
        if (tick_sum_s >= T_MAX_EXT) begin
          tick_next_s = T_MAX;
        end else begin
          tick_next_s = tick_sum_s[PERIOD_BITS-1:0];
        end
      end
    end

    // Stage 2: arm FSM with registered raw period, valid strobe and lost flag.
    // Timeout outranks a mode change, which outranks an edge.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        prev_bit_r <= 1'b0;
        mode_d_r   <= 1'b0;
        tick_r     <= '0;
        state_r    <= ST_DISARMED;
        raw_r      <= '0;
        valid_r    <= 1'b0;
        lost_r     <= 1'b1;
        direct_r   <= 1'b0;
      end else begin
        prev_bit_r <= word_r[SAMPLE_BITS-1];
        mode_d_r   <= mode_r;
        tick_r     <= tick_next_s;
        valid_r    <= 1'b0;
        if (sat_s) begin
          state_r <= ST_DISARMED;
          lost_r  <= 1'b1;
        end else if (mode_chg_s) begin
          state_r <= ST_DISARMED;
        end else if (edge_s) begin
          case (state_r)
            ST_DISARMED: begin
              state_r <= ST_ARMED;
            end
            ST_ARMED: begin
              raw_r    <= period_s[PERIOD_BITS-1:0];
              valid_r  <= 1'b1;
              direct_r <= lost_r;
              lost_r   <= 1'b0;
              state_r  <= ST_TRACKING;
            end
            ST_TRACKING: begin
              raw_r    <= period_s[PERIOD_BITS-1:0];
              valid_r  <= 1'b1;
              direct_r <= lost_r;
              lost_r   <= 1'b0;
            end
            default: begin
              state_r <= ST_DISARMED;
            end
          endcase
        end else begin
          state_r <= state_r;
        end
      end
    end

    // First-order IIR step towards the new sample; negative results clamp to 0.
    always_comb begin
      x_s    = {raw_r, {FRAC{1'b0}}};
      diff_s = $signed({1'b0, x_s}) - $signed({1'b0, filt_r});
      sum_s  = $signed({1'b0, filt_r}) + (diff_s >>> FILTER_SHIFT_BITS);
      if (sum_s[DATA_BITS]) begin
        filt_next_s = '0;
      end else begin
        filt_next_s = sum_s[DATA_BITS-1:0];
      end
    end

    // Stage 3: load directly after a lost signal, otherwise smooth.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        filt_r <= '0;
      end else if (valid_r) begin
        if (direct_r) begin
          filt_r <= x_s;
        end else begin
          filt_r <= filt_next_s;
        end
      end else begin
        filt_r <= filt_r;
      end
    end

    assign PERIOD_RAW[c*PERIOD_BITS +: PERIOD_BITS]    = raw_r;
    assign PERIOD_FILTERED[c*DATA_BITS +: DATA_BITS]   = filt_r;
    assign PERIOD_VALID[c]                             = valid_r;
    assign SIGNAL_LOST[c]                              = lost_r;
  end

endmodule

// File: tb/tb_theremin_multichannel_period_measure.sv
// Bench for theremin_multichannel_period_measure (2 channels, SB=8, PB=16,
// DB=28, FS=8). Square-wave generators feed a sample-level reference model
// that pushes expected {cycle, channel, period, filtered} records into a
// scoreboard queue; the per-cycle monitor pops and compares them. A vector
// table covers in-word edge-position corner cases.
module tb_theremin_multichannel_period_measure;

  localparam int CH = 2, SB = 8, PB = 16, DB = 28, FS = 8;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [CH*SB-1:0] SAMPLES = '0;
  logic [CH-1:0]  EDGE_MODE = '0;
  logic [CH*PB-1:0] PERIOD_RAW;
  logic [CH*DB-1:0] PERIOD_FILTERED;
  logic [CH-1:0]  PERIOD_VALID;
  logic [CH-1:0]  SIGNAL_LOST;

  theremin_multichannel_period_measure #(
    .CHANNELS(CH), .SAMPLE_BITS(SB), .PERIOD_BITS(PB),
    .DATA_BITS(DB), .FILTER_SHIFT_BITS(FS)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SAMPLES(SAMPLES), .EDGE_MODE(EDGE_MODE),
    .PERIOD_RAW(PERIOD_RAW), .PERIOD_FILTERED(PERIOD_FILTERED),
    .PERIOD_VALID(PERIOD_VALID), .SIGNAL_LOST(SIGNAL_LOST)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int            due;
    int            ch;
    logic [PB-1:0] period;
    logic [DB-1:0] filt;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic          mode;
    logic [7:0]    w1, w2, w3;
    bit            v2;
    logic [PB-1:0] r2;
    bit            v3;
    logic [PB-1:0] r3;
  } vec_t;
  vec_t tbl[6];

  // reference model state
  logic [DB-1:0] m_f[CH];
  logic          m_lost[CH], m_ml[CH], m_mode[CH];
  bit            m_armed[CH], m_sat[CH];
  int            m_last[CH], m_sat_due[CH];
  int            gn;
  // pending filtered-output checks
  bit            fp[CH];
  int            fdue[CH];
  logic [DB-1:0] fexp[CH];
  // generators
  logic          g_lvl[CH], gm[CH];
  bit            g_en[CH];
  int            g_cnt[CH], g_hi[CH], g_lo[CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DB-1:0] filt_step(input logic [DB-1:0] f, input logic [PB-1:0] raw,
                                              input bit direct);
    logic [DB-1:0] x;
    logic signed [DB:0] d, s;
    x = {raw, 12'd0};
    if (direct) return x;
    d = $signed({1'b0, x}) - $signed({1'b0, f});
    s = $signed({1'b0, f}) + (d >>> FS);
    return s[DB-1:0];
  endfunction

  task automatic push_valid(input int c, input logic [PB-1:0] p, input int due);
    sb_t e;
    m_f[c] = filt_step(m_f[c], p, m_lost[c]);
    m_lost[c] = 1'b0;
    e.due = due; e.ch = c; e.period = p; e.filt = m_f[c];
    sbq.push_back(e);
  endtask

  task automatic monitor();
    sb_t e;
    bit got[CH];
    for (int c = 0; c < CH; c++) got[c] = 1'b0;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk($sformatf("valid_ch%0d_due%0d", e.ch, e.due), 64'(PERIOD_VALID[e.ch]), 64'd1);
      chk($sformatf("raw_ch%0d", e.ch), 64'(PERIOD_RAW[e.ch*PB +: PB]), 64'(e.period));
      chk($sformatf("lost_on_valid_ch%0d", e.ch), 64'(SIGNAL_LOST[e.ch]), 64'd0);
      got[e.ch] = 1'b1;
      fp[e.ch] = 1'b1; fdue[e.ch] = cyc + 1; fexp[e.ch] = e.filt;
    end
    for (int c = 0; c < CH; c++) begin
      if (!got[c]) chk($sformatf("no_valid_ch%0d", c), 64'(PERIOD_VALID[c]), 64'd0);
      if (fp[c] && fdue[c] == cyc) begin
        chk($sformatf("filtered_ch%0d", c), 64'(PERIOD_FILTERED[c*DB +: DB]), 64'(fexp[c]));
        fp[c] = 1'b0;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    monitor();
  endtask

  task automatic model_init();
    gn = SB;
    for (int c = 0; c < CH; c++) begin
      m_f[c] = '0; m_lost[c] = 1'b1; m_ml[c] = 1'b0; m_mode[c] = 1'b0;
      m_armed[c] = 1'b0; m_sat[c] = 1'b0; m_last[c] = 0; m_sat_due[c] = -1;
      fp[c] = 1'b0;
    end
    sbq.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_raw"}, 64'(PERIOD_RAW), 64'd0);
    chk({tag, "_filt"}, 64'(PERIOD_FILTERED), 64'd0);
    chk({tag, "_valid"}, 64'(PERIOD_VALID), 64'd0);
    chk({tag, "_lost"}, 64'(SIGNAL_LOST), 64'd3);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_init();
    next_cycle();
    next_cycle();
    check_reset_state("reset");
    RESET = 1'b0;
    model_init();
  endtask

  // Sample-level reference: one word of one channel.
  task automatic model_word(input int c, input logic [SB-1:0] w, input logic mode);
    bit has = 1'b0, sat;
    int en = 0;
    for (int i = 0; i < SB; i++) begin
      if (w[i] != m_ml[c] && (!mode || w[i])) begin has = 1'b1; en = gn + i; end
      m_ml[c] = w[i];
    end
    sat = !m_sat[c] && (has ? (en - m_last[c] >= 65535) : (gn + SB - m_last[c] >= 65535));
    if (sat) begin
      m_armed[c] = 1'b0; m_lost[c] = 1'b1; m_sat_due[c] = cyc + 2;
    end else if (mode != m_mode[c]) begin
      m_armed[c] = 1'b0;
    end else if (has) begin
      if (m_armed[c]) push_valid(c, PB'(en - m_last[c]), cyc + 2);
      else m_armed[c] = 1'b1;
    end
    if (has) begin m_last[c] = en; m_sat[c] = 1'b0; end
    else if (sat) m_sat[c] = 1'b1;
    m_mode[c] = mode;
  endtask

  task automatic gen_bit(input int c, output logic b);
    b = g_lvl[c];
    if (g_en[c]) begin
      g_cnt[c]--;
      if (g_cnt[c] == 0) begin
        g_lvl[c] = ~g_lvl[c];
        g_cnt[c] = g_lvl[c] ? g_hi[c] : g_lo[c];
      end
    end
  endtask

  task automatic drive_gen();
    logic [SB-1:0] w;
    logic b;
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < SB; i++) begin gen_bit(c, b); w[i] = b; end
      SAMPLES[c*SB +: SB] = w;
      EDGE_MODE[c] = gm[c];
      model_word(c, w, gm[c]);
    end
    gn += SB;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin drive_gen(); next_cycle(); end
  endtask

  task automatic drive_raw(input logic [7:0] w, input logic mode);
    SAMPLES = {8'h00, w};
    EDGE_MODE = {1'b0, mode};
  endtask

  initial begin
    bit found, mono;
    logic [DB-1:0] prev_f, cur_f;
    logic [7:0] fill;

    // mode, w1, w2, w3, valid@w2, raw@w2, valid@w3, raw@w3
    tbl[0] = '{1'b0, 8'hFE, 8'h33, 8'hF8, 1'b1, 16'd13, 1'b1, 16'd5};
    tbl[1] = '{1'b1, 8'hFE, 8'h33, 8'hF8, 1'b1, 16'd11, 1'b1, 16'd7};
    tbl[2] = '{1'b0, 8'hFE, 8'h00, 8'hFF, 1'b1, 16'd7,  1'b1, 16'd8};
    tbl[3] = '{1'b1, 8'hFE, 8'h00, 8'hFF, 1'b0, 16'd0,  1'b1, 16'd15};
    tbl[4] = '{1'b0, 8'h80, 8'hD5, 8'h00, 1'b1, 16'd7,  1'b1, 16'd2};
    tbl[5] = '{1'b1, 8'h80, 8'hD5, 8'h00, 1'b1, 16'd7,  1'b0, 16'd0};

    // Edge-position vectors: arming word, measured word, follow-up word.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      drive_raw(8'h00, tbl[v].mode); next_cycle();
      drive_raw(tbl[v].w1, tbl[v].mode); next_cycle();
      drive_raw(tbl[v].w2, tbl[v].mode);
      if (tbl[v].v2) push_valid(0, tbl[v].r2, cyc + 2);
      next_cycle();
      drive_raw(tbl[v].w3, tbl[v].mode);
      if (tbl[v].v3) push_valid(0, tbl[v].r3, cyc + 2);
      next_cycle();
      fill = {8{tbl[v].w3[7]}};
      for (int k = 0; k < 4; k++) begin drive_raw(fill, tbl[v].mode); next_cycle(); end
      chk($sformatf("table%0d_drained", v), 64'(sbq.size()), 64'd0);
    end

    // Ch0 any-edge 37/37, ch1 rising-only 30/50 in parallel.
    do_reset();
    for (int c = 0; c < CH; c++) begin g_lvl[c] = 1'b0; g_cnt[c] = 40; g_en[c] = 1'b1; end
    g_hi[0] = 37; g_lo[0] = 37; gm[0] = 1'b0;
    g_hi[1] = 30; g_lo[1] = 50; gm[1] = 1'b1;
    run(9);
    chk("lost_before_first_valid", 64'(SIGNAL_LOST), 64'd3);
    run(400);
    chk("ch0_raw_37", 64'(PERIOD_RAW[15:0]), 64'd37);
    chk("ch1_raw_80", 64'(PERIOD_RAW[31:16]), 64'd80);
    chk("ch0_filt_151552", 64'(PERIOD_FILTERED[27:0]), 64'd151552);
    chk("lost_cleared", 64'(SIGNAL_LOST), 64'd0);

    // Step ch0 to 45-tick half periods.
    g_hi[0] = 45; g_lo[0] = 45;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      run(1);
      if (PERIOD_VALID[0] && PERIOD_RAW[15:0] == 16'd45) found = 1'b1;
    end
    chk("step45_seen", 64'(found), 64'd1);
    run(1);
    chk("filt_first_step", 64'(PERIOD_FILTERED[27:0]), 64'd151680);
    mono = 1'b1;
    prev_f = PERIOD_FILTERED[27:0];
    for (int k = 0; k < 3000; k++) begin
      run(1);
      cur_f = PERIOD_FILTERED[27:0];
      if (cur_f < prev_f) mono = 1'b0;
      prev_f = cur_f;
    end
    chk("filt_monotonic", 64'(mono), 64'd1);
    chk("filt_rising", 64'(prev_f > 28'd151680), 64'd1);
    chk("filt_bounded", 64'(prev_f <= 28'd184320), 64'd1);

    // Ch0 edges stop: timeout after ~65535 ticks, outputs hold.
    g_en[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 9000 && !found; k++) begin
      run(1);
      if (SIGNAL_LOST[0]) found = 1'b1;
    end
    chk("timeout_lost", 64'(found), 64'd1);
    chk("timeout_cycle", 64'(cyc), 64'(m_sat_due[0]));
    chk("timeout_raw_hold", 64'(PERIOD_RAW[15:0]), 64'd45);
    chk("timeout_filt_hold", 64'(PERIOD_FILTERED[27:0]), 64'(m_f[0]));
    chk("ch1_unaffected", 64'(SIGNAL_LOST[1]), 64'd0);

    // Restart at 37: first edge only arms, second loads the filter directly.
    g_hi[0] = 37; g_lo[0] = 37; g_en[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      run(1);
      if (PERIOD_VALID[0]) found = 1'b1;
    end
    chk("restart_valid", 64'(found), 64'd1);
    run(1);
    chk("restart_direct_load", 64'(PERIOD_FILTERED[27:0]), 64'd151552);
    run(100);

    // Edge mode toggled mid-stream: disarm, lost unchanged.
    gm[0] = 1'b1;
    run(3);
    chk("modechg_lost_kept", 64'(SIGNAL_LOST[0]), 64'd0);
    run(100);
    chk("mode1_raw_74", 64'(PERIOD_RAW[15:0]), 64'd74);
    gm[0] = 1'b0;
    run(100);

    // Asynchronous reset mid-cycle.
    #2 RESET = 1'b1;
    #1 check_reset_state("async_reset");
    model_init();
    next_cycle();
    next_cycle();
    RESET = 1'b0;
    model_init();
    run(200);

    g_en[0] = 1'b0; g_en[1] = 1'b0;
    run(20);
    chk("final_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
